// File: rtl/alu_muldiv_unit.sv
// Multi-cycle signed multiply / restoring divide unit writing HI/LO.
// Operands are latched as magnitudes; signs are applied in a final fix-up cycle.
module alu_muldiv_unit #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  MUL_CODE = 4'b1111,
  parameter logic [3:0]  DIV_CODE = 4'b0011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  // Handshake: start is sampled only while idle with a mult/div code; busy rises
  // on that accept edge, and WIDTH+1 edges later done pulses for one cycle as
  // busy falls and hi/lo update. start is ignored at all other times.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               accept;

  assign abs_a  = a[WIDTH-1] ? -a : a;
  assign abs_b  = b[WIDTH-1] ? -b : b;
  assign accept = (state == S_IDLE) && start &&
                  ((alu_ctrl == MUL_CODE) || (alu_ctrl == DIV_CODE));

  // One iteration. Divide keeps {remainder, quotient} in acc and pulls dividend
  // bits MSB-first out of mag_a; multiply adds a left-shifting multiplicand.
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] mcand_nxt;
  logic [WIDTH-1:0]   mag_a_nxt;
  logic [WIDTH-1:0]   mag_b_nxt;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;

  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    mag_a_nxt = mag_a;
    mag_b_nxt = mag_b;
    rem_shift = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
    trial     = rem_shift - {1'b0, mag_b};
    if (op_div) begin
      mag_a_nxt = mag_a << 1;
      if (!trial[WIDTH]) begin
        acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (mag_b[0]) begin
        acc_nxt = acc + mcand;
      end
      mcand_nxt = mcand << 1;
      mag_b_nxt = mag_b >> 1;
    end
  end

  // Sign fix-up; a zero divisor leaves the remainder equal to |a|, so the
  // remainder path alone restores the original dividend into hi.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (op_div) begin
      hi_fix = rem_fix;
      lo_fix = b_zero ? {WIDTH{1'b1}} : quot_fix;
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      op_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_div <= (alu_ctrl == DIV_CODE);
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            b_zero <= (b == '0);
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand_nxt;
          mag_a <= mag_a_nxt;
          mag_b <= mag_b_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          done        <= 1'b1;
          div_by_zero <= op_div && b_zero;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  a_done_one_cycle: assert property (@(posedge clk) disable iff (reset) done |=> !done);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy && done));

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed scenarios plus random mult/div traffic,
// scored against a signed-arithmetic reference model.
module tb_alu_muldiv_unit;

  localparam int         W        = 32;
  localparam logic [3:0] MUL      = 4'b1111;
  localparam logic [3:0] DIV      = 4'b0011;
  localparam int         LATENCY  = W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  alu_muldiv_unit #(.WIDTH(W), .MUL_CODE(MUL), .DIV_CODE(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_ctrl    (alu_ctrl),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {div_by_zero, hi, lo}
  logic [2*W:0] exp_q[$];

  int           e0_cycle;
  logic [W-1:0] hold_hi;
  logic [W-1:0] hold_lo;
  logic         mid_change;
  logic         stray_dbz;

  function automatic logic [2*W:0] model(input logic [3:0] code, input logic [W-1:0] oa,
                                         input logic [W-1:0] ob);
    longint sa, sb, p, q, r;
    logic [63:0] pb;
    sa = longint'(signed'(oa));
    sb = longint'(signed'(ob));
    if (code == MUL) begin
      p  = sa * sb;
      pb = p;
      return {1'b0, pb};
    end
    if (ob == '0) return {1'b1, oa, {W{1'b1}}};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction

  // driver: present a request, return 1ns after the accept edge
  task automatic issue(input logic [3:0] code, input logic [W-1:0] oa, input logic [W-1:0] ob);
    @(negedge clk);
    hold_hi    = hi;
    hold_lo    = lo;
    mid_change = 1'b0;
    stray_dbz  = 1'b0;
    start      = 1'b1;
    alu_ctrl   = code;
    a          = oa;
    b          = ob;
    exp_q.push_back(model(code, oa, ob));
    @(posedge clk);
    #1;
    e0_cycle = cycle;
    start    = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [2*W:0] obs, output logic ok);
    ok  = 1'b0;
    lat = -1;
    obs = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ok  = 1'b1;
        lat = cycle - e0_cycle;
        obs = {div_by_zero, hi, lo};
        break;
      end
      if (hi !== hold_hi || lo !== hold_lo) mid_change = 1'b1;
      if (div_by_zero !== 1'b0) stray_dbz = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b1;
    alu_ctrl = MUL;
    a        = 32'd7;
    b        = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if ({hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_mult_basic();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok;
    issue(MUL, 32'd7, 32'hFFFF_FFFD);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_busy_e0: got %b expected 1", busy);
    end
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || lat != LATENCY) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d expected %0d", lat, LATENCY);
    end
    n_checks++;
    if (obs !== exp || obs !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      n_fail++;
      $display("FAIL mult_7x-3: got %h expected %h", obs, exp);
    end
    n_checks++;
    if (mid_change !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_hilo_stable: got %b expected 0", mid_change);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL mult_done_pulse: got %b expected 00", {done, busy});
    end
  endtask

  task automatic test_div();
    logic [W-1:0] ta[3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [W-1:0] tb[3] = '{32'd7,   32'd2,         32'hFFFF_FFFF};
    logic [2*W:0] tx[3] = '{{1'b0, 32'd2, 32'd14},
                            {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {1'b0, 32'd0, 32'h8000_0000}};
    int lat;
    logic [2*W:0] obs, exp;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      issue(DIV, ta[i], tb[i]);
      wait_done(lat, obs, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || lat != LATENCY) begin
        n_fail++;
        $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, LATENCY);
      end
      n_checks++;
      if (obs !== exp || obs !== tx[i]) begin
        n_fail++;
        $display("FAIL div_result[%0d]: got %h expected %h", i, obs, tx[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok;
    issue(DIV, 32'd5, 32'd0);
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || lat != LATENCY) begin
      n_fail++;
      $display("FAIL dbz_latency: got %0d expected %0d", lat, LATENCY);
    end
    n_checks++;
    if (obs !== exp || obs !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL dbz_result: got %h expected %h", obs, exp);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({div_by_zero, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL dbz_one_cycle: got %b expected 00", {div_by_zero, done});
    end
    issue(DIV, 32'd50, 32'd6);
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || obs !== exp || stray_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_then_normal: got %h/%b expected %h/0", obs, stray_dbz, exp);
    end
  endtask

  task automatic test_min_mult_and_ignore();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok, saw_busy, saw_done;
    issue(MUL, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || obs !== exp || obs !== {1'b0, 32'h4000_0000, 32'h0}) begin
      n_fail++;
      $display("FAIL mult_min_min: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = 4'b0010;
    a        = $urandom();
    b        = $urandom();
    saw_busy = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) saw_busy = 1'b1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if ({saw_busy, saw_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL bad_code_ignored: got %b expected 00", {saw_busy, saw_done});
    end
    n_checks++;
    if ({hi, lo} !== obs[2*W-1:0]) begin
      n_fail++;
      $display("FAIL bad_code_hilo: got %h expected %h", {hi, lo}, obs[2*W-1:0]);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok;
    issue(DIV, 32'hFFFF_FC18, 32'd33);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = MUL;
    a        = 32'd9;
    b        = 32'd9;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || lat != LATENCY || obs !== exp) begin
      n_fail++;
      $display("FAIL start_while_busy: got %h lat %0d expected %h lat %0d", obs, lat, exp, LATENCY);
    end
    n_checks++;
    if (mid_change !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_hilo_stable: got %b expected 0", mid_change);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok;
    issue(MUL, 32'd123456, 32'hFFFF_0001);
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || obs !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected %h", obs, exp);
    end
    issue(DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
    n_checks++;
    if (busy !== 1'b1 || e0_cycle != cycle) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy %b expected 1", busy);
    end
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || lat != LATENCY || obs !== exp) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat %0d expected %h lat %0d", obs, lat, exp, LATENCY);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok, saw_done;
    issue(MUL, 32'h1234_5678, 32'h0FED_CBA9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL abort_state: got %h expected 0", {busy, done, hi, lo});
    end
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %b expected 0", saw_done);
    end
    issue(MUL, 32'd3, 32'd4);
    wait_done(lat, obs, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || obs !== exp || obs !== {1'b0, 32'd0, 32'd12}) begin
      n_fail++;
      $display("FAIL abort_then_mult: got %h expected %h", obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  task automatic test_random();
    int lat;
    logic [2*W:0] obs, exp;
    logic ok;
    logic [3:0] code;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      code = ($urandom_range(0, 1) == 0) ? MUL : DIV;
      ra   = pick();
      rb   = pick();
      issue(code, ra, rb);
      wait_done(lat, obs, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || lat != LATENCY || obs !== exp || mid_change !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] op %b a %h b %h: got %h lat %0d expected %h lat %0d",
                 i, code, ra, rb, obs, lat, exp, LATENCY);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    alu_ctrl = 4'b0000;
    a        = '0;
    b        = '0;
    test_reset();
    test_mult_basic();
    test_div();
    test_div_zero();
    test_min_mult_and_ignore();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
